// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default parameters and the parity rule
// used by both the transmitter and the planned receiver.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DIV_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // par_typ=1 gives even parity (XOR of data), par_typ=0 odd parity (XNOR).
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    return par_typ ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: loaded at each bit start, bit_done while it sits at zero.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             bit_done
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frm.sv
// Parametrised UART transmitter: start, DATA_WIDTH data bits LSB first, optional
// parity, 1 or 2 stop bits, runtime bit period, zero-gap back-to-back frames.
module uart_tx_frm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DIV_W      = DIV_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIV_W-1:0]      PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW = $clog2(DATA_WIDTH);

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] frame_data_q, frame_data_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic [DIV_W-1:0]      prescale_q, prescale_d;

  logic                  bit_done, last_stop, accept, baud_load;
  logic [DIV_W-1:0]      baud_val;

  // PRESCALE of 0 or 1 both give a one-cycle bit.
  function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] pre);
    return (pre == '0) ? '0 : pre - DIV_W'(1);
  endfunction

  assign last_stop = (state_q == ST_STOP) && bit_done && (stop_idx_q == stop2_q);
  assign accept    = DATA_VALID && ((state_q == ST_IDLE) || last_stop);
  assign baud_load = accept || (bit_done && (state_q != ST_IDLE) && !last_stop);
  assign baud_val  = accept ? reload_val(PRESCALE) : reload_val(prescale_q);

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .CLK      (CLK),
    .RST      (RST),
    .load     (baud_load),
    .load_val (baud_val),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    frame_data_d = frame_data_q;
    par_bit_d    = par_bit_q;
    par_en_d     = par_en_q;
    stop2_d      = stop2_q;
    prescale_d   = prescale_q;
    if (accept) begin
      state_d      = ST_START;
      tx_d         = 1'b0;
      busy_d       = 1'b1;
      bit_idx_d    = '0;
      stop_idx_d   = 1'b0;
      frame_data_d = P_DATA;
      par_bit_d    = parity_bit(^P_DATA, PAR_TYP);
      par_en_d     = PAR_EN;
      stop2_d      = STOP2;
      prescale_d   = PRESCALE;
    end else if (bit_done) begin
      unique case (state_q)
        ST_START: begin
          state_d = ST_DATA;
          tx_d    = frame_data_q[0];
        end
        ST_DATA: begin
          if (bit_idx_q == BW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
            tx_d    = par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_idx_d    = bit_idx_q + BW'(1);
            frame_data_d = frame_data_q >> 1;
            tx_d         = frame_data_q[1];
          end
        end
        ST_PARITY: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
        ST_STOP: begin
          if (stop_idx_q != stop2_q) begin
            stop_idx_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame payload registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
    end
    frame_data_q <= frame_data_d;
    par_bit_q    <= par_bit_d;
    par_en_q     <= par_en_d;
    stop2_q      <= stop2_d;
    prescale_q   <= prescale_d;
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frm.sv
// Directed bench for uart_tx_frm: per-cycle {Busy,TX_OUT} expectations queued at
// stimulus time and compared cycle by cycle.
module tb_uart_tx_frm;

  localparam int DW  = 8;
  localparam int DVW = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [DVW-1:0] PRESCALE = '0;
  logic           PAR_EN = 1'b0;
  logic           PAR_TYP = 1'b0;
  logic           STOP2 = 1'b0;
  logic [DW-1:0]  P_DATA = '0;
  logic           DATA_VALID = 1'b0;
  logic           TX_OUT;
  logic           Busy;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_frm #(.DATA_WIDTH(DW), .DIV_W(DVW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: busy,tx observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  // Independent frame model: one {busy,tx} entry per clock cycle.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input logic s2, input int pre);
    int   reps;
    int   ones;
    logic bits[$];
    reps = (pre < 1) ? 1 : pre;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) bits.push_back(pt ? ones[0] : !ones[0]);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int r = 0; r < reps; r++) exp_q.push_back({1'b1, bits[i]});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b01);
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s: scoreboard empty, observed busy,tx=%b", tag, {Busy, TX_OUT});
      end else begin
        check(tag, {Busy, TX_OUT}, exp_q.pop_front());
      end
      tick();
    end
  endtask

  task automatic drain_all(input string tag);
    drain(tag, exp_q.size());
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic s2, input int pre);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP2      = s2;
    PRESCALE   = DVW'(pre);
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
  endtask

  initial begin
    logic [10:0] pat11;
    logic [9:0]  pat10;

    // Reset state
    RST = 1'b0;
    tick();
    tick();
    check("reset", {Busy, TX_OUT}, 2'b01);
    RST = 1'b1;
    tick();
    check("post_reset_idle", {Busy, TX_OUT}, 2'b01);

    // 0x5D, odd parity, one stop, 1 cycle/bit: literal line pattern
    send(8'h5D, 1'b1, 1'b0, 1'b0, 1);
    pat11 = 11'b01011101001;
    for (int i = 10; i >= 0; i--) exp_q.push_back({1'b1, pat11[i]});
    push_idle(2);
    drain_all("par_odd_5d");

    // Even parity flips the parity bit
    send(8'h5D, 1'b1, 1'b1, 1'b0, 1);
    push_frame(8'h5D, 1'b1, 1'b1, 1'b0, 1);
    push_idle(2);
    drain_all("par_even_5d");

    // No parity: 10-cycle frame
    send(8'h5D, 1'b0, 1'b0, 1'b0, 0);
    pat10 = 10'b0101110101;
    for (int i = 9; i >= 0; i--) exp_q.push_back({1'b1, pat10[i]});
    push_idle(2);
    drain_all("nopar_5d");

    // PRESCALE=4, two stop bits: 44-cycle frame
    send(8'hA5, 1'b0, 1'b0, 1'b1, 4);
    push_frame(8'hA5, 1'b0, 1'b0, 1'b1, 4);
    push_idle(2);
    drain_all("pre4_stop2_a5");

    // Back-to-back: DATA_VALID held, word switched in the last stop cycle
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1);
    DATA_VALID = 1'b1;
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1);
    push_frame(8'h62, 1'b1, 1'b0, 1'b0, 1);
    push_idle(2);
    drain("b2b_first", 10);
    P_DATA = 8'h62;
    drain("b2b_last_stop", 1);
    DATA_VALID = 1'b0;
    drain_all("b2b_second");

    // Input changes and a stray request mid-frame are ignored
    send(8'h3C, 1'b1, 1'b1, 1'b0, 2);
    push_frame(8'h3C, 1'b1, 1'b1, 1'b0, 2);
    push_idle(3);
    drain("midchg_a", 5);
    P_DATA   = 8'hFF;
    PAR_TYP  = 1'b0;
    PRESCALE = 16'd7;
    drain("midchg_b", 3);
    DATA_VALID = 1'b1;
    drain("midchg_pulse", 1);
    DATA_VALID = 1'b0;
    drain_all("midchg_rest");

    // Reset during the data phase, then a fresh frame
    send(8'h96, 1'b0, 1'b0, 1'b0, 3);
    push_frame(8'h96, 1'b0, 1'b0, 1'b0, 3);
    drain("pre_rst", 8);
    RST = 1'b0;
    tick();
    check("rst_mid_frame", {Busy, TX_OUT}, 2'b01);
    exp_q.delete();
    RST = 1'b1;
    tick();
    check("rst_release_idle", {Busy, TX_OUT}, 2'b01);
    send(8'h5D, 1'b1, 1'b0, 1'b0, 3);
    push_frame(8'h5D, 1'b1, 1'b0, 1'b0, 3);
    push_idle(2);
    drain_all("after_rst_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
